// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory. It alternates
// ownership round-robin, supports locked bursts and forces release of a lock held too long.
module data_mem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          wr_a,
    input  logic          wr_b,
    input  logic          lock_a,
    input  logic          lock_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          rvalid_a,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t     state_q, state_d;
    logic       prio_q, prio_d;     // 0 = port A wins a tie, 1 = port B
    logic [3:0] hold_q, hold_d;
    logic       rvalid_a_q, rvalid_b_q;
    logic       hold_expired;

    assign hold_expired = (hold_q >= HOLD_MAX);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            hold_q     <= 4'd0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            hold_q     <= hold_d;
            rvalid_a_q <= gnt_a & ~wr_a;
            rvalid_b_q <= gnt_b & ~wr_b;
        end
    end

    always_comb begin
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        state_d = IDLE;
        hold_d  = 4'd0;
        prio_d  = prio_q;

        unique case (state_q)
            LOCK_A: begin
                if (req_a) begin
                    if (req_b && hold_expired) gnt_b = 1'b1;
                    else                       gnt_a = 1'b1;
                end else begin
                    gnt_b = req_b;
                end
            end
            LOCK_B: begin
                if (req_b) begin
                    if (req_a && hold_expired) gnt_a = 1'b1;
                    else                       gnt_b = 1'b1;
                end else begin
                    gnt_a = req_a;
                end
            end
            default: begin
                if (req_a && req_b) begin
                    gnt_a = ~prio_q;
                    gnt_b = prio_q;
                end else begin
                    gnt_a = req_a;
                    gnt_b = req_b;
                end
            end
        endcase

        // The hold counter only grows while the same port keeps re-locking.
        if (gnt_a) begin
            prio_d = 1'b1;
            if (lock_a) begin
                state_d = LOCK_A;
                if (state_q == LOCK_A) hold_d = hold_expired ? HOLD_MAX : hold_q + 4'd1;
                else                   hold_d = 4'd1;
            end
        end else if (gnt_b) begin
            prio_d = 1'b0;
            if (lock_b) begin
                state_d = LOCK_B;
                if (state_q == LOCK_B) hold_d = hold_expired ? HOLD_MAX : hold_q + 4'd1;
                else                   hold_d = 4'd1;
            end
        end
    end

    assign mem_en      = gnt_a | gnt_b;
    assign mem_wr      = gnt_b ? wr_b : (gnt_a & wr_a);
    assign mem_addr    = gnt_b ? addr_b : addr_a;
    assign mem_wdata   = gnt_b ? wdata_b : wdata_a;
    assign rvalid_a    = rvalid_a_q;
    assign rvalid_b    = rvalid_b_q;
    assign rdata       = mem_rdata;
    assign owner_state = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized and directed bench for data_mem_arbiter, checked against an ownership/memory model.
module tb_data_mem_arbiter;

    localparam int AW       = 8;
    localparam int DW       = 16;
    localparam int MAX_HOLD = 8;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          req_a, req_b, wr_a, wr_b, lock_a, lock_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    owner_state;

    data_mem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_a(req_a), .req_b(req_b), .wr_a(wr_a), .wr_b(wr_b),
        .lock_a(lock_a), .lock_b(lock_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata(rdata), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner_state(owner_state)
    );

    always #5 Clk = ~Clk;

    // Environment memory: one-cycle registered read data.
    logic [DW-1:0] ram [256];
    always @(posedge Clk) begin
        if (mem_en) begin
            if (mem_wr) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Model state: owner 0 none / 1 A / 2 B, who wins the next tie, how long the owner has held.
    int            checks = 0;
    int            errors = 0;
    int            m_owner;
    bit            m_prio_b;
    int            m_hold;
    bit            m_rv_a, m_rv_b;
    logic [DW-1:0] mdl_mem [256];
    logic [DW-1:0] exp_q [$];

    logic          s_ga, s_gb, s_en, s_wr, s_rva, s_rvb;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [1:0]    s_own;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner for this cycle: 0 none, 1 A, 2 B.
    function automatic int pick(input logic ra, input logic rb);
        int me, other;
        logic r_me, r_other;
        if (m_owner != 0) begin
            me      = m_owner;
            other   = 3 - m_owner;
            r_me    = (me == 1) ? ra : rb;
            r_other = (me == 1) ? rb : ra;
            if (r_me) return (r_other && m_hold >= MAX_HOLD) ? other : me;
            return r_other ? other : 0;
        end
        if (ra && rb) return m_prio_b ? 2 : 1;
        if (ra) return 1;
        if (rb) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_owner  = 0;
        m_prio_b = 1'b0;
        m_hold   = 0;
        m_rv_a   = 1'b0;
        m_rv_b   = 1'b0;
        exp_q.delete();
    endtask

    task automatic step(input logic ra, input logic rb, input logic wa, input logic wb,
                        input logic la, input logic lb, input logic [AW-1:0] aa,
                        input logic [AW-1:0] ab, input logic [DW-1:0] da, input logic [DW-1:0] db);
        int            w;
        logic          e_wr, locking;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        req_a = ra; req_b = rb; wr_a = wa; wr_b = wb; lock_a = la; lock_b = lb;
        addr_a = aa; addr_b = ab; wdata_a = da; wdata_b = db;
        @(negedge Clk);
        w      = pick(ra, rb);
        e_addr = (w == 2) ? ab : aa;
        e_wd   = (w == 2) ? db : da;
        e_wr   = (w == 1) ? wa : (w == 2) ? wb : 1'b0;
        chk("gnt_a", gnt_a, w == 1);
        chk("gnt_b", gnt_b, w == 2);
        chk("mem_en", mem_en, w != 0);
        chk("mem_wr", mem_wr, e_wr);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("owner_state", owner_state, m_owner);
        chk("rvalid_a", rvalid_a, m_rv_a);
        chk("rvalid_b", rvalid_b, m_rv_b);
        if (m_rv_a || m_rv_b) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdata: no expected read data queued at %0t", $time);
            end else begin
                chk("rdata", rdata, exp_q.pop_front());
            end
        end
        s_ga = gnt_a; s_gb = gnt_b; s_en = mem_en; s_wr = mem_wr; s_addr = mem_addr;
        s_wdata = mem_wdata; s_rva = rvalid_a; s_rvb = rvalid_b; s_rdata = rdata; s_own = owner_state;

        m_rv_a = (w == 1) && !wa;
        m_rv_b = (w == 2) && !wb;
        if (w != 0) begin
            if (e_wr) mdl_mem[e_addr] = e_wd;
            else      exp_q.push_back(mdl_mem[e_addr]);
            m_prio_b = (w == 1);
            locking  = (w == 1) ? la : lb;
            if (!locking)           begin m_hold = 0; m_owner = 0; end
            else if (m_owner == w)  m_hold = (m_hold + 1 > MAX_HOLD) ? MAX_HOLD : m_hold + 1;
            else                    begin m_hold = 1; m_owner = w; end
        end else begin
            m_owner = 0;
            m_hold  = 0;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_a = 0; req_b = 0; wr_a = 0; wr_b = 0; lock_a = 0; lock_b = 0;
        addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset_owner", owner_state, 2'd0);
        chk("reset_rvalid", {rvalid_a, rvalid_b}, 2'b00);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int cnt_a;
        bit seen_b;
        idle_inputs();
        Reset_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = DW'($urandom);
            mdl_mem[i] = ram[i];
        end
        ram[8'h10]     = 16'h1234;
        mdl_mem[8'h10] = 16'h1234;
        do_reset();

        // Both ports request continuously without lock: strict alternation.
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 1, 1, 0, 0, 8'h21, 8'h42, 16'h0a0a, 16'h0b0b);
            chk("alt_gnt_a", s_ga, (i % 2) == 0);
            chk("alt_addr", s_addr, (i % 2) == 0 ? 8'h21 : 8'h42);
        end

        // Single read by A returns memory data one cycle later.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 8'h10, 8'h00, 16'h0, 16'h0);
        step(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0, 16'h0);
        chk("rd_rvalid_a", s_rva, 1'b1);
        chk("rd_rdata", s_rdata, 16'h1234);
        chk("rd_rvalid_b", s_rvb, 1'b0);
        step(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0, 16'h0);
        chk("rd_rvalid_a_once", s_rva, 1'b0);

        // A locks while B waits: A holds MAX_HOLD grants, then B is forced in.
        do_reset();
        cnt_a  = 0;
        seen_b = 0;
        for (int i = 0; i < 9; i++) begin
            step(1, 1, 0, 1, 1, 0, AW'(8'h40 + i), 8'h50, 16'h0, 16'h5555);
            if (!seen_b && s_ga) cnt_a++;
            if (s_gb) seen_b = 1;
        end
        chk("hold_run_a", cnt_a, MAX_HOLD);
        chk("forced_gnt_b", s_gb, 1'b1);
        step(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0, 16'h0);
        chk("forced_leaves_lock", s_own, 2'd0);

        // A locks then drops its request; B then writes.
        do_reset();
        step(1, 0, 1, 0, 1, 0, 8'h07, 8'h00, 16'h1111, 16'h0);
        step(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0, 16'h0);
        chk("drop_lock_owner", s_own, 2'd1);
        chk("drop_no_gnt", {s_ga, s_gb}, 2'b00);
        step(0, 1, 0, 1, 0, 0, 8'h00, 8'h05, 16'h0, 16'hbeef);
        chk("wr_owner_idle", s_own, 2'd0);
        chk("wr_mem_en", s_en, 1'b1);
        chk("wr_mem_wr", s_wr, 1'b1);
        chk("wr_mem_addr", s_addr, 8'h05);
        chk("wr_mem_wdata", s_wdata, 16'hbeef);
        step(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0, 16'h0);
        chk("wr_no_rvalid", {s_rva, s_rvb}, 2'b00);

        // Asynchronous reset during LOCK_B with a read in flight.
        do_reset();
        step(0, 1, 0, 0, 0, 1, 8'h00, 8'h30, 16'h0, 16'h0);
        step(0, 1, 0, 0, 0, 1, 8'h00, 8'h31, 16'h0, 16'h0);
        chk("pre_rst_owner", owner_state, 2'd2);
        chk("pre_rst_rvalid_b", rvalid_b, 1'b1);
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_owner", owner_state, 2'd0);
        chk("async_rst_rvalid_b", rvalid_b, 1'b0);
        req_a = 1; req_b = 1; lock_a = 0; lock_b = 0; wr_a = 0; wr_b = 0;
        #1;
        chk("rst_gnt_a_with_req", gnt_a, 1'b1);
        chk("rst_gnt_b_with_req", gnt_b, 1'b0);
        @(posedge Clk);
        @(negedge Clk);
        idle_inputs();
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        step(1, 1, 0, 0, 0, 0, 8'h60, 8'h61, 16'h0, 16'h0);
        chk("post_rst_first_a", s_ga, 1'b1);
        chk("post_rst_no_rvalid", {s_rva, s_rvb}, 2'b00);
        step(1, 1, 0, 0, 0, 0, 8'h62, 8'h63, 16'h0, 16'h0);
        chk("post_rst_then_b", s_gb, 1'b1);

        // Random traffic with frequent locking to exercise forced release.
        for (int i = 0; i < 3000; i++) begin
            logic ra, rb;
            ra = ($urandom_range(0, 9) < 8);
            rb = ($urandom_range(0, 9) < 7);
            step(ra, rb, 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                 AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom));
            if (s_rva && s_rvb) begin
                checks++;
                errors++;
                $display("FAIL rvalid_both: both rvalid high at %0t", $time);
            end
            if (i % 1000 == 999) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
